// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment controller: valid/ready value load, sequential binary-to-BCD
// (shift-add-3) or direct hex nibbles, leading-zero blanking, per-digit DP, overflow dashes.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned REFRESH_DIV = 262144
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_data,
  input  logic              mode_hex,
  input  logic              blank_lz,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              overflow
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PW = $clog2(REFRESH_DIV);
  localparam int unsigned CW = $clog2(DATA_W);

  localparam logic [6:0] SegZero  = 7'b0000001;
  localparam logic [6:0] SegDash  = 7'b1111110;
  localparam logic [6:0] SegBlank = 7'b1111111;

  function automatic logic [63:0] pow10(int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

  // Largest value representable in DIGITS decimal digits.
  localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] glyph(logic [3:0] nib, logic hex);
    logic [6:0] g;
    case (nib)
      4'h0:    g = 7'b0000001;
      4'h1:    g = 7'b1001111;
      4'h2:    g = 7'b0010010;
      4'h3:    g = 7'b0000110;
      4'h4:    g = 7'b1001100;
      4'h5:    g = 7'b0100100;
      4'h6:    g = 7'b0100000;
      4'h7:    g = 7'b0001111;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0000100;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b1100000;
      4'hC:    g = 7'b0110001;
      4'hD:    g = 7'b1000010;
      4'hE:    g = 7'b0110000;
      4'hF:    g = 7'b0111000;
      default: g = SegZero;
    endcase
    if (!hex && (nib > 4'd9)) begin
      g = SegZero;
    end
    return g;
  endfunction

  typedef enum logic [1:0] {StIdle, StConv, StCommit} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              pend_hex_q, pend_hex_d;
  logic              pend_blank_q, pend_blank_d;
  logic              pend_ovf_q, pend_ovf_d;
  logic [BW-1:0]     buf_q, buf_d;
  logic              disp_hex_q, disp_hex_d;
  logic              disp_blank_q, disp_blank_d;
  logic              ovf_q, ovf_d;

  logic [PW-1:0]     presc_q;
  logic [KW-1:0]     k_q;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic [BW-1:0]     hex_nib;
  logic              hex_ovf;

  // Hex mode: nibbles come straight from the captured value; bits above the display overflow.
  if (DATA_W > BW) begin : g_hex_wide
    assign hex_nib = shift_q[BW-1:0];
    assign hex_ovf = |load_data[DATA_W-1:BW];
  end else if (DATA_W == BW) begin : g_hex_eq
    assign hex_nib = shift_q;
    assign hex_ovf = 1'b0;
  end else begin : g_hex_narrow
    assign hex_nib = {{(BW - DATA_W){1'b0}}, shift_q};
    assign hex_ovf = 1'b0;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    pend_hex_d   = pend_hex_q;
    pend_blank_d = pend_blank_q;
    pend_ovf_d   = pend_ovf_q;
    buf_d        = buf_q;
    disp_hex_d   = disp_hex_q;
    disp_blank_d = disp_blank_q;
    ovf_d        = ovf_q;
    load_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        load_ready = 1'b1;
        if (load_valid) begin
          shift_d      = load_data;
          bcd_d        = '0;
          cnt_d        = '0;
          pend_hex_d   = mode_hex;
          pend_blank_d = blank_lz;
          pend_ovf_d   = mode_hex ? hex_ovf : (64'(load_data) > DEC_MAX);
          state_d      = mode_hex ? StCommit : StConv;
        end
      end
      StConv: begin
        bcd_d   = (bcd_adj << 1) | BW'(shift_q[DATA_W-1]);
        shift_d = shift_q << 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        // Buffer, mode, blanking and overflow change together so no torn frame is shown.
        buf_d        = pend_hex_q ? hex_nib : bcd_q;
        disp_hex_d   = pend_hex_q;
        disp_blank_d = pend_blank_q;
        ovf_d        = pend_ovf_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bcd_q        <= '0;
      cnt_q        <= '0;
      pend_hex_q   <= 1'b0;
      pend_blank_q <= 1'b0;
      pend_ovf_q   <= 1'b0;
      buf_q        <= '0;
      disp_hex_q   <= 1'b0;
      disp_blank_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bcd_q        <= bcd_d;
      cnt_q        <= cnt_d;
      pend_hex_q   <= pend_hex_d;
      pend_blank_q <= pend_blank_d;
      pend_ovf_q   <= pend_ovf_d;
      buf_q        <= buf_d;
      disp_hex_q   <= disp_hex_d;
      disp_blank_q <= disp_blank_d;
      ovf_q        <= ovf_d;
    end
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      k_q     <= '0;
    end else if (presc_q == PW'(REFRESH_DIV - 1)) begin
      presc_q <= '0;
      k_q     <= (k_q == KW'(DIGITS - 1)) ? '0 : k_q + KW'(1);
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  logic [KW-1:0]     act;
  logic [3:0]        nib;
  logic [DIGITS-1:0] lz;
  logic              seen;
  logic              blank_now;

  always_comb begin
    // Scan slot k drives digit DIGITS-1-k so the most-significant digit comes first.
    act  = KW'(DIGITS - 1) - k_q;
    nib  = buf_q[4*act +: 4];
    lz   = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (buf_q[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end
      lz[i] = !seen;
    end
    blank_now = disp_blank_q && !ovf_q && lz[act];
    if (ovf_q) begin
      seg_d = SegDash;
    end else if (blank_now) begin
      seg_d = SegBlank;
    end else begin
      seg_d = glyph(nib, disp_hex_q);
    end
    anode_d = ~(DIGITS'(1) << act);
    dp_d    = ~dp_mask[act];
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      anode_q <= '1;
      seg_q   <= SegBlank;
      dp_q    <= 1'b1;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign anode    = anode_q;
  assign seg      = seg_q;
  assign dp       = dp_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl: directed and random loads checked against a
// digit-arithmetic reference model of the scanned display.
module tb_seg7_scan_ctrl;

  logic        clock_100Mhz = 1'b0;
  logic        reset        = 1'b0;
  logic        load_valid   = 1'b0;
  logic        load_ready;
  logic [15:0] load_data    = '0;
  logic        mode_hex     = 1'b0;
  logic        blank_lz     = 1'b0;
  logic [3:0]  dp_mask      = '0;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;
  logic        overflow;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  int unsigned ncyc  = 0;
  int unsigned acc_cnt = 0;

  int unsigned m_val   = 0;
  bit          m_hex   = 1'b0;
  bit          m_blank = 1'b0;
  bit          m_ovf   = 1'b0;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100, 7'b0100000,
    7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010,
    7'b0110000, 7'b0111000};

  seg7_scan_ctrl #(
    .DIGITS      (4),
    .DATA_W      (16),
    .REFRESH_DIV (4)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_data    (load_data),
    .mode_hex     (mode_hex),
    .blank_lz     (blank_lz),
    .dp_mask      (dp_mask),
    .anode        (anode),
    .seg          (seg),
    .dp           (dp),
    .overflow     (overflow)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  // Clock edges since reset release; the scan slot follows from this alone.
  always @(posedge clock_100Mhz or posedge reset) begin
    if (reset) ncyc <= 0;
    else       ncyc <= ncyc + 1;
  end

  always @(posedge clock_100Mhz) begin
    if (!reset && load_valid && load_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic do_check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    assert (got === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [6:0] exp_seg(input int j);
    int unsigned hi, d, base;
    if (m_ovf) return 7'b1111110;
    if (m_hex) begin
      hi = m_val >> (4 * j);
      d  = hi % 16;
    end else begin
      base = 1;
      for (int i = 0; i < j; i++) base = base * 10;
      hi = m_val / base;
      d  = hi % 10;
    end
    if (m_blank && j != 0 && hi == 0) return 7'b1111111;
    return GLYPH[d];
  endfunction

  task automatic set_model(input int unsigned v, input bit hex, input bit blank);
    m_val   = v;
    m_hex   = hex;
    m_blank = blank;
    m_ovf   = hex ? ((v >> 16) != 0) : (v > 9999);
  endtask

  task automatic check_reset();
    do_check("rst_anode", {28'b0, anode}, 32'hF);
    do_check("rst_seg", {25'b0, seg}, 32'h7F);
    do_check("rst_dp", {31'b0, dp}, 32'h1);
    do_check("rst_ready", {31'b0, load_ready}, 32'h1);
    do_check("rst_overflow", {31'b0, overflow}, 32'h0);
  endtask

  task automatic check_scan(input int n);
    int unsigned k;
    int j;
    for (int i = 0; i < n; i++) begin
      @(negedge clock_100Mhz);
      k = ((ncyc - 1) / 4) % 4;
      j = 3 - int'(k);
      do_check("scan_anode", {28'b0, anode}, {28'b0, ~(4'b0001 << j)});
      do_check("scan_seg", {25'b0, seg}, {25'b0, exp_seg(j)});
      do_check("scan_dp", {31'b0, dp}, {31'b0, ~dp_mask[j]});
    end
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!load_ready && t < 200) begin
      @(negedge clock_100Mhz);
      t++;
    end
    if (!load_ready) do_check("ready_timeout", {31'b0, load_ready}, 32'h1);
  endtask

  task automatic do_load(input int unsigned v, input bit hex, input bit blank, input bit hold,
                         input int exp_busy);
    int busy;
    int unsigned acc0;
    wait_ready();
    load_data  = v[15:0];
    mode_hex   = hex;
    blank_lz   = blank;
    load_valid = 1'b1;
    acc0       = acc_cnt;
    @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    if (!hold) load_valid = 1'b0;
    busy = 0;
    while (!load_ready && busy < 100) begin
      busy++;
      @(negedge clock_100Mhz);
    end
    load_valid = 1'b0;
    do_check("busy_cycles", busy, exp_busy);
    do_check("accept_count", acc_cnt - acc0, 32'd1);
    set_model(v, hex, blank);
    do_check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  initial begin
    int unsigned v;
    int unsigned sel;
    bit          hx;
    bit          bl;

    // Power-on reset.
    #2 reset = 1'b1;
    repeat (3) @(negedge clock_100Mhz);
    check_reset();
    reset = 1'b0;
    set_model(0, 1'b0, 1'b0);
    check_scan(16);

    // Reset pulse mid-scan.
    repeat (5) @(negedge clock_100Mhz);
    reset = 1'b1;
    #1 check_reset();
    @(negedge clock_100Mhz);
    reset = 1'b0;
    check_scan(16);

    do_load(1234, 1'b0, 1'b0, 1'b0, 17);
    check_scan(16);
    do_load(10000, 1'b0, 1'b0, 1'b0, 17);
    check_scan(16);
    do_load(42, 1'b0, 1'b0, 1'b0, 17);
    check_scan(16);
    do_load(32'hBEEF, 1'b1, 1'b0, 1'b0, 1);
    check_scan(16);

    dp_mask = 4'b0001;
    do_load(7, 1'b0, 1'b1, 1'b0, 17);
    check_scan(16);
    do_load(0, 1'b0, 1'b1, 1'b0, 17);
    check_scan(16);

    for (int r = 0; r < 8; r++) begin
      sel = $urandom_range(0, 2);
      if (sel == 0)      v = $urandom_range(0, 65535);
      else if (sel == 1) v = $urandom_range(0, 9999);
      else               v = $urandom_range(0, 99);
      hx      = 1'($urandom_range(0, 1));
      bl      = 1'($urandom_range(0, 1));
      dp_mask = 4'($urandom);
      do_load(v, hx, bl, 1'b0, hx ? 1 : 17);
      check_scan(16);
    end

    // Reset during conversion of 9999 aborts it.
    dp_mask = 4'b0000;
    wait_ready();
    load_data  = 16'd9999;
    mode_hex   = 1'b0;
    blank_lz   = 1'b0;
    load_valid = 1'b1;
    @(posedge clock_100Mhz);
    @(negedge clock_100Mhz);
    load_valid = 1'b0;
    repeat (4) @(negedge clock_100Mhz);
    reset = 1'b1;
    #1 check_reset();
    @(negedge clock_100Mhz);
    reset = 1'b0;
    set_model(0, 1'b0, 1'b0);
    check_scan(16);
    do_check("abort_overflow", {31'b0, overflow}, 32'h0);

    // load_valid held through the busy window must be accepted exactly once.
    do_load(321, 1'b0, 1'b0, 1'b1, 17);
    check_scan(16);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller. It accepts a binary value over a valid/ready load port and converts it to BCD with a sequential shift-add-3 engine, so no combinational divide is used. It also supports a hex display mode, leading-zero blanking, per-digit decimal points and overflow indication. The block sits between the value-producing datapath (DSP/BRAM/counters) and the board anode/cathode pins, and supersedes the fixed 4-digit controller.

## Interface
- DIGITS, 4: number of digits/anodes; 1..8.
- DATA_W, 16: load_data width; 4..32.
- REFRESH_DIV, 262144: clock cycles per digit slot; ≥2.

Ports:
- clock_100Mhz  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- load_valid  in  1  new value offered.
- load_ready  out  1  block can accept a value.
- load_data  in  DATA_W  unsigned value.
- mode_hex  in  1  1 = hex nibbles, 0 = decimal; sampled on accept.
- blank_lz  in  1  leading-zero blanking enable; sampled on accept.
- dp_mask  in  DIGITS  live; bit i=1 lights the DP of digit i.
- anode  out  DIGITS  active-low digit enables; anode[0] = rightmost/least-significant digit.
- seg  out  7  active-low cathodes {a,b,c,d,e,f,g}, seg[6]=a.
- dp  out  1  active-low decimal point.
- overflow  out  1  last committed value did not fit.

## Operation
- FSM states:
  - IDLE: load_ready=1.
  - CONV: BCD shift-add-3, one binary bit per cycle, DATA_W cycles.
  - COMMIT: one cycle.
- Transfers:
  - A transfer occurs when load_valid & load_ready.
  - Decimal mode: IDLE→CONV→COMMIT→IDLE.
  - Hex mode: IDLE→COMMIT→IDLE (nibbles copied directly).
- load_valid while not ready is ignored; the producer holds it.
- Decimal conversion:
  - BCD register is 4*DIGITS bits.
  - Before each shift, every nibble ≥5 gets +3.
- Overflow rules:
  - Decimal: load_data > 10^DIGITS−1 (constant at elaboration).
  - Hex: any load_data bit ≥ 4*DIGITS is nonzero.
  - On overflow, COMMIT writes all digits as dash and sets overflow=1; otherwise overflow=0.
- COMMIT writes the display buffer, stored mode and stored blank_lz atomically, so a torn display is never shown.
- Scan:
  - Prescaler counts 0..REFRESH_DIV−1.
  - At the terminal count, scan index k increments and wraps DIGITS−1→0.
  - Slot k drives digit j=DIGITS−1−k: anode[j]=0, all other anodes 1, so the most-significant digit comes first.
- Glyphs (seg, active-low):
  - Digits: 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111, 8 0000000, 9 0000100.
  - Hex letters: A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000.
  - Dash 1111110; blank 1111111.
  - Decimal-mode nibble >9 cannot occur; default to 0 glyph.
- Leading-zero blanking:
  - Applies when stored blank_lz=1 and the value is not overflowed.
  - Zero digits above the most-significant nonzero digit show blank.
  - Digit 0 is never blanked.
- dp = ~dp_mask[j] for the active digit, independent of blanking and overflow.

## Timing
- Reset (async assert, sync release):
  - Outputs: anode all 1, seg 1111111, dp 1, overflow 0, load_ready 1.
  - Internal: buffer 0, mode decimal, blank_lz 0, prescaler 0, k=0, FSM IDLE.
- anode/seg/dp are registered, updated one cycle after k changes.
  - First digit is driven in the first cycle after reset release.
- Decimal accept at edge T:
  - load_ready low from T+1.
  - CONV runs cycles T+1..T+DATA_W; COMMIT in cycle T+DATA_W+1.
  - New buffer and load_ready=1 from T+DATA_W+2.
- Hex accept at T: COMMIT at T+1; visible and ready from T+2.
- Refresh tick coincident with COMMIT: both take effect; the next registered output uses the new buffer.
- Reset mid-CONV/COMMIT aborts the conversion; the pending value is never displayed.
- dp_mask changes appear at the next registered output update.

## Test plan
Parameters: DIGITS=4, DATA_W=16, REFRESH_DIV=4.
- Reset pulse mid-scan -> anode=1111, seg=1111111, dp=1, load_ready=1, overflow=0; after release the scan shows 0 on all four digits (blank_lz=0).
- Load 1234 decimal, blank_lz=0 -> load_ready low for 17 cycles; scan shows anode 0111/1001111, 1011/0010010, 1101/0000110, 1110/1001100.
- Load 10000 decimal -> overflow=1, every slot seg=1111111→1111110 (dash); then load 42 -> overflow=0, digits 0,0,4,2.
- Load 0xBEEF, mode_hex=1 -> ready again 2 cycles after accept; digits b,E,E,F (1100000, 0110000, 0110000, 0111000).
- Load 7 with blank_lz=1, dp_mask=0001 -> anodes 3..1 show 1111111 with dp=1; digit 0 shows 0001111 with dp=0. Load 0 -> digit 0 shows 0000001.
- Load 9999 decimal; assert reset at T+5 -> display never shows 9999; after release buffer=0 and load_ready=1; a load_valid held high through busy accepts exactly once.
